flow_redirect: RTL
==================

Name: flow_redirect

Overview:
- Fetch-side consumer of the EX-stage flow-change decision.
- Owns the fetch PC register and computes the redirect target for branches, immediate jumps and register jumps.
- Issues the pipeline flush and holds a redirect pending across pipeline stalls.
- Handles HLT: fetch freezes until a redirect or reset.

Parameters:
PC_W, 16, width of PC and jump-register target
BR_OFF_W, 9, branch offset width (signed, two's complement)
JMP_OFF_W, 12, immediate-jump offset width (signed)
RST_PC, 0, PC value after reset

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flow_change_ID_EX  input  1  redirect request from the branch-condition unit
br_instr_ID_EX  input  1  EX instruction is a conditional branch
jmp_imm_ID_EX  input  1  EX instruction is an immediate jump
jmp_reg_ID_EX  input  1  EX instruction is a register jump
pc_ID_EX  input  PC_W  PC+1 of the EX instruction
br_off_ID_EX  input  BR_OFF_W  branch offset
jmp_off_ID_EX  input  JMP_OFF_W  jump offset
reg_tgt_ID_EX  input  PC_W  register-jump target (forwarded operand)
stall  input  1  global pipeline stall; fetch PC must hold
hlt_ID  input  1  HLT decoded in ID
pc  output  PC_W  fetch address to instruction memory
pc_IF_ID  output  PC_W  pc+1, sent down the pipeline
flush  output  1  squash IF/ID and ID/EX this cycle
halted  output  1  fetch frozen by HLT

Behaviour:
- Reset (asynchronous, any state, including mid-pending): pc=RST_PC, state=RUN, pending target cleared, flush=0, halted=0.
- Target computation (combinational):
  - Priority jmp_reg > jmp_imm > branch.
  - jmp_reg: reg_tgt_ID_EX.
  - jmp_imm: pc_ID_EX + sign-extended jmp_off_ID_EX.
  - branch: pc_ID_EX + sign-extended br_off_ID_EX.
  - Sum is modulo 2^PC_W; wrap-around is silent.
  - flow_change_ID_EX with no type bit set: target = pc_ID_EX.
- pc_IF_ID = pc+1, modulo 2^PC_W.
- States: RUN, PEND, HALT.
- RUN:
  - stall=0, flow_change=0, hlt_ID=0: pc<=pc+1.
  - stall=0, flow_change=1: flush=1 combinationally this cycle; pc<=target; stay RUN.
  - stall=1, flow_change=1: capture target into the pending register; go to PEND; flush=0; pc holds.
  - stall=1, flow_change=0: pc holds.
  - hlt_ID=1, stall=0, flow_change=0: pc holds; go to HALT.
  - flow_change and hlt_ID both 1: redirect wins (HLT is younger and gets flushed); no HALT entry.
- PEND:
  - pc holds while stall=1.
  - Inputs are ignored while pending.
  - First cycle with stall=0: flush=1, pc<=pending target, go to RUN.
- HALT:
  - halted=1, pc frozen.
  - flow_change=1 with stall=0: flush=1, pc<=target, go to RUN.
  - flow_change=1 with stall=1: capture target, go to PEND.
  - Otherwise stays in HALT until reset.
- flush is 0 whenever stall=1.
- Latency: one cycle from accepted redirect to the new pc at the fetch port.

Optional Feature:
- Macro REDIRECT_PERF_EN.
- Defined:
  - Adds output redirect_cnt (32 bits) and output stall_pend_cnt (32 bits).
  - redirect_cnt increments on every cycle with flush=1.
  - stall_pend_cnt increments on every cycle spent in PEND.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then 4 free-run cycles -> pc 0,1,2,3,4; pc_IF_ID=pc+1; flush=0.
- Branch: pc_ID_EX=0x0010, br_off=9'h1F0 (-16), flow_change=1, br_instr=1 -> flush=1 that cycle; next pc=0x0000.
- Register jump: jmp_reg=1 and jmp_imm=1, reg_tgt=0xBEEF, flow_change=1 -> next pc=0xBEEF (priority check).
- Stall hold: stall=1 with jmp_imm, pc_ID_EX=0xFFF0, jmp_off=12'h020; drop flow_change; hold stall 3 cycles -> pc frozen, flush=0; first unstalled cycle flush=1; next pc=0x0010 (wrap-around).
- Halt: hlt_ID=1 at pc=0x0040 -> halted=1, pc stays 0x0040 for 10 cycles; branch to 0x0100 -> flush=1, halted=0, next pc=0x0100.
- Reset asserted during PEND -> pc=RST_PC immediately; pending target discarded; no flush after release.

Source files
------------

// File: rtl/flow_redirect.sv
// Fetch PC owner: applies EX-stage redirects, holds a redirect pending across stalls, freezes on HLT.
// Optional macro REDIRECT_PERF_EN adds saturating redirect / pending-cycle counters.
module flow_redirect #(
    parameter int unsigned     PC_W      = 16,
    parameter int unsigned     BR_OFF_W  = 9,
    parameter int unsigned     JMP_OFF_W = 12,
    parameter logic [PC_W-1:0] RST_PC    = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flow_change_ID_EX,
    input  logic                 br_instr_ID_EX,
    input  logic                 jmp_imm_ID_EX,
    input  logic                 jmp_reg_ID_EX,
    input  logic [PC_W-1:0]      pc_ID_EX,
    input  logic [BR_OFF_W-1:0]  br_off_ID_EX,
    input  logic [JMP_OFF_W-1:0] jmp_off_ID_EX,
    input  logic [PC_W-1:0]      reg_tgt_ID_EX,
    input  logic                 stall,
    input  logic                 hlt_ID,
    output logic [PC_W-1:0]      pc,
    output logic [PC_W-1:0]      pc_IF_ID,
    output logic                 flush,
    output logic                 halted
`ifdef REDIRECT_PERF_EN
    ,
    output logic [31:0]          redirect_cnt,
    output logic [31:0]          stall_pend_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pend_tgt, pend_tgt_next;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] br_ext, jmp_ext;

    assign br_ext  = {{(PC_W-BR_OFF_W){br_off_ID_EX[BR_OFF_W-1]}}, br_off_ID_EX};
    assign jmp_ext = {{(PC_W-JMP_OFF_W){jmp_off_ID_EX[JMP_OFF_W-1]}}, jmp_off_ID_EX};

    always_comb begin
        target = pc_ID_EX;
        if (jmp_reg_ID_EX)
            target = reg_tgt_ID_EX;
        else if (jmp_imm_ID_EX)
            target = pc_ID_EX + jmp_ext;
        else if (br_instr_ID_EX)
            target = pc_ID_EX + br_ext;
    end

    assign pc_IF_ID = pc + 1'b1;
    assign halted   = (state == HALT);

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        pend_tgt_next = pend_tgt;
        flush         = 1'b0;
        unique case (state)
            RUN: begin
                if (flow_change_ID_EX && !stall) begin
                    flush   = 1'b1;
                    pc_next = target;
                end else if (flow_change_ID_EX) begin
                    pend_tgt_next = target;
                    state_next    = PEND;
                end else if (!stall) begin
                    if (hlt_ID)
                        state_next = HALT;
                    else
                        pc_next = pc + 1'b1;
                end
            end
            PEND: begin
                if (!stall) begin
                    flush      = 1'b1;
                    pc_next    = pend_tgt;
                    state_next = RUN;
                end
            end
            HALT: begin
                if (flow_change_ID_EX && !stall) begin
                    flush      = 1'b1;
                    pc_next    = target;
                    state_next = RUN;
                end else if (flow_change_ID_EX) begin
                    pend_tgt_next = target;
                    state_next    = PEND;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RST_PC;
            pend_tgt <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            pend_tgt <= pend_tgt_next;
        end
    end

`ifdef REDIRECT_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt   <= '0;
            stall_pend_cnt <= '0;
        end else begin
            if (flush && redirect_cnt != '1)
                redirect_cnt <= redirect_cnt + 1'b1;
            if (state == PEND && stall_pend_cnt != '1)
                stall_pend_cnt <= stall_pend_cnt + 1'b1;
        end
    end
`endif

endmodule
